// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_arb CPU-to-memory request arbiter.
package mem_arb_pkg;

  localparam int unsigned REQ_AW = 32;
  localparam int unsigned REQ_DW = 32;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_t;

  typedef struct packed {
    logic [REQ_AW-1:0] addr;
    logic [1:0]        size;
    logic              wen;
    logic [REQ_DW-1:0] wdata;
    logic [3:0]        wmask;
  } req_t;

endpackage

// File: rtl/mem_arb_slot.sv
// One-entry pending request buffer: captures a request when empty, holds it until popped.
module mem_arb_slot
  import mem_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  req_t i_data,
  input  logic i_pop,
  output logic o_valid,
  output req_t o_data
);

  logic r_valid;
  req_t r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_push && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/mem_arb.sv
// Serializes CPU fetch and load/store requests onto one memory port, LSU first,
// with registered responses and a per-transaction timeout.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ifu_reqValid,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_respValid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_reqValid,
  input  logic [AW-1:0] lsu_addr,
  input  logic [1:0]    lsu_size,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [3:0]    lsu_wmask,
  output logic          lsu_respValid,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_reqValid,
  input  logic          mem_reqReady,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_size,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_respValid,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  if (AW != REQ_AW || DW != REQ_DW) begin : g_bad_width
    $error("mem_arb: AW/DW must match the mem_arb_pkg request widths");
  end

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  owner_t        r_owner;
  logic [TW-1:0] r_tmo;
  req_t          r_mem;
  logic          r_ifu_resp, r_lsu_resp, r_bus_err;
  logic [DW-1:0] r_ifu_rdata, r_lsu_rdata;

  logic          w_busy, w_ifu_push, w_lsu_push, w_ifu_pop, w_lsu_pop;
  logic          w_ifu_valid, w_lsu_valid;
  logic          w_tmo_hit, w_resp_ok, w_done;
  logic [DW-1:0] w_rdata;
  req_t          w_ifu_in, w_lsu_in, w_ifu_q, w_lsu_q;

  assign w_busy = (r_state != IDLE);

  // A port is blocked only while its own transaction is in flight; on its
  // response-pulse cycle the FSM is back in IDLE so a new request is taken.
  assign w_ifu_push = ifu_reqValid && !(w_busy && r_owner == OWN_IFU);
  assign w_lsu_push = lsu_reqValid && !(w_busy && r_owner == OWN_LSU);

  // Fetches are always full words with no write payload.
  assign w_ifu_in = '{addr: ifu_addr, size: SIZE_WORD, wen: 1'b0, wdata: '0, wmask: '0};
  assign w_lsu_in = '{addr: lsu_addr, size: lsu_size, wen: lsu_wen, wdata: lsu_wdata,
                      wmask: lsu_wmask};

  mem_arb_slot u_ifu_slot (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_ifu_push),
    .i_data  (w_ifu_in),
    .i_pop   (w_ifu_pop),
    .o_valid (w_ifu_valid),
    .o_data  (w_ifu_q)
  );

  mem_arb_slot u_lsu_slot (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_lsu_push),
    .i_data  (w_lsu_in),
    .i_pop   (w_lsu_pop),
    .o_valid (w_lsu_valid),
    .o_data  (w_lsu_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ifu_pop   = 1'b0;
    w_lsu_pop   = 1'b0;
    w_resp_ok   = 1'b0;
    w_done      = 1'b0;
    w_tmo_hit   = w_busy && (r_tmo == TMO_LAST);
    case (r_state)
      IDLE: begin
        if (w_lsu_valid) begin
          w_lsu_pop   = 1'b1;
          w_state_nxt = REQ;
        end else if (w_ifu_valid) begin
          w_ifu_pop   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_tmo_hit) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (mem_reqReady) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_resp_ok = mem_respValid;
        if (mem_respValid || w_tmo_hit) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A real response arriving on the timeout cycle wins over the error word.
  assign w_rdata = w_resp_ok ? mem_rdata : ERR_DATA;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IFU;
      r_tmo       <= '0;
      r_mem       <= '0;
      r_ifu_resp  <= 1'b0;
      r_lsu_resp  <= 1'b0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ifu_resp <= w_done && (r_owner == OWN_IFU);
      r_lsu_resp <= w_done && (r_owner == OWN_LSU);
      if (w_lsu_pop) begin
        r_owner <= OWN_LSU;
        r_mem   <= w_lsu_q;
        r_tmo   <= '0;
      end else if (w_ifu_pop) begin
        r_owner <= OWN_IFU;
        r_mem   <= w_ifu_q;
        r_tmo   <= '0;
      end else if (w_busy) begin
        r_tmo <= r_tmo + TW'(1);
      end
      if (w_done) begin
        if (r_owner == OWN_IFU) r_ifu_rdata <= w_rdata;
        else                    r_lsu_rdata <= w_rdata;
      end
      if (w_tmo_hit && !w_resp_ok) r_bus_err <= 1'b1;
    end
  end

  assign mem_reqValid  = (r_state == REQ);
  assign mem_addr      = r_mem.addr;
  assign mem_size      = r_mem.size;
  assign mem_wen       = r_mem.wen;
  assign mem_wdata     = r_mem.wdata;
  assign mem_wmask     = r_mem.wmask;
  assign ifu_respValid = r_ifu_resp;
  assign ifu_rdata     = r_ifu_rdata;
  assign lsu_respValid = r_lsu_resp;
  assign lsu_rdata     = r_lsu_rdata;
  assign bus_err       = r_bus_err;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: hand-timed memory responses, expected values written inline.
module tb_mem_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_arb #(
    .AW       (32),
    .DW       (32),
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_reqValid  (ifu_reqValid),
    .ifu_addr      (ifu_addr),
    .ifu_respValid (ifu_respValid),
    .ifu_rdata     (ifu_rdata),
    .lsu_reqValid  (lsu_reqValid),
    .lsu_addr      (lsu_addr),
    .lsu_size      (lsu_size),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_respValid (lsu_respValid),
    .lsu_rdata     (lsu_rdata),
    .mem_reqValid  (mem_reqValid),
    .mem_reqReady  (mem_reqReady),
    .mem_addr      (mem_addr),
    .mem_size      (mem_size),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_respValid (mem_respValid),
    .mem_rdata     (mem_rdata),
    .bus_err       (bus_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ifu_respValid"}, 32'(ifu_respValid), 32'd0);
    chk({tag, ".ifu_rdata"},     ifu_rdata,           32'd0);
    chk({tag, ".lsu_respValid"}, 32'(lsu_respValid), 32'd0);
    chk({tag, ".lsu_rdata"},     lsu_rdata,           32'd0);
    chk({tag, ".mem_reqValid"},  32'(mem_reqValid),  32'd0);
    chk({tag, ".mem_addr"},      mem_addr,            32'd0);
    chk({tag, ".mem_size"},      32'(mem_size),      32'd0);
    chk({tag, ".mem_wen"},       32'(mem_wen),       32'd0);
    chk({tag, ".mem_wdata"},     mem_wdata,           32'd0);
    chk({tag, ".mem_wmask"},     32'(mem_wmask),     32'd0);
    chk({tag, ".bus_err"},       32'(bus_err),       32'd0);
  endtask

  initial begin
    reset = 1'b0;
    ifu_reqValid = 1'b0; ifu_addr = '0;
    lsu_reqValid = 1'b0; lsu_addr = '0; lsu_size = '0; lsu_wen = 1'b0;
    lsu_wdata = '0; lsu_wmask = '0;
    mem_reqReady = 1'b1; mem_respValid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single fetch; memory answers one cycle after the accept cycle.
    ifu_reqValid = 1'b1; ifu_addr = 32'h8000_0000;
    tick();                                   // N: captured
    ifu_reqValid = 1'b0;
    chk("fetch.no_req_yet", 32'(mem_reqValid), 32'd0);
    tick();                                   // N+1: arbitrated into REQ
    chk("fetch.reqValid", 32'(mem_reqValid), 32'd1);
    chk("fetch.addr", mem_addr, 32'h8000_0000);
    chk("fetch.wen", 32'(mem_wen), 32'd0);
    tick();                                   // accepted, now RESP
    chk("fetch.req_drop", 32'(mem_reqValid), 32'd0);
    tick();
    mem_respValid = 1'b1; mem_rdata = 32'h0000_0013;
    chk("fetch.no_resp_early", 32'(ifu_respValid), 32'd0);
    tick();
    mem_respValid = 1'b0; mem_rdata = '0;
    chk("fetch.respValid", 32'(ifu_respValid), 32'd1);
    chk("fetch.rdata", ifu_rdata, 32'h0000_0013);
    chk("fetch.lsu_quiet", 32'(lsu_respValid), 32'd0);
    tick();
    chk("fetch.pulse_one", 32'(ifu_respValid), 32'd0);
    chk("fetch.bus_err", 32'(bus_err), 32'd0);

    // Simultaneous fetch and load: LSU first, IFU right after.
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_0100;
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_0200; lsu_wen = 1'b0; lsu_size = 2'b10;
    tick();
    ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
    tick();
    chk("both.lsu_first_valid", 32'(mem_reqValid), 32'd1);
    chk("both.lsu_first_addr", mem_addr, 32'h0000_0200);
    tick();
    mem_respValid = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick();
    mem_respValid = 1'b0;
    chk("both.lsu_resp", 32'(lsu_respValid), 32'd1);
    chk("both.lsu_rdata", lsu_rdata, 32'hAAAA_0001);
    chk("both.ifu_not_yet", 32'(ifu_respValid), 32'd0);
    chk("both.idle_gap", 32'(mem_reqValid), 32'd0);
    tick();
    chk("both.ifu_second_valid", 32'(mem_reqValid), 32'd1);
    chk("both.ifu_second_addr", mem_addr, 32'h0000_0100);
    chk("both.lsu_pulse_one", 32'(lsu_respValid), 32'd0);
    tick();
    mem_respValid = 1'b1; mem_rdata = 32'h0000_0EEE;
    tick();
    mem_respValid = 1'b0;
    chk("both.ifu_resp", 32'(ifu_respValid), 32'd1);
    chk("both.ifu_rdata", ifu_rdata, 32'h0000_0EEE);
    chk("both.not_coincident", 32'(lsu_respValid), 32'd0);
    tick();

    // Store held off by reqReady=0 for three cycles.
    mem_reqReady = 1'b0;
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_0010; lsu_size = 2'b00; lsu_wen = 1'b1;
    lsu_wdata = 32'h00AB_0000; lsu_wmask = 4'b0100;
    tick();
    lsu_reqValid = 1'b0; lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
    lsu_wen = 1'b0; lsu_size = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("store.valid_held", 32'(mem_reqValid), 32'd1);
      chk("store.addr", mem_addr, 32'h0000_0010);
      chk("store.wdata", mem_wdata, 32'h00AB_0000);
      chk("store.wmask", 32'(mem_wmask), 32'h4);
      chk("store.wen", 32'(mem_wen), 32'd1);
      chk("store.size", 32'(mem_size), 32'd0);
    end
    mem_reqReady = 1'b1;
    tick();
    chk("store.accepted", 32'(mem_reqValid), 32'd0);
    chk("store.no_resp_yet", 32'(lsu_respValid), 32'd0);
    mem_respValid = 1'b1; mem_rdata = 32'h5555_0000;
    tick();
    mem_respValid = 1'b0;
    chk("store.resp", 32'(lsu_respValid), 32'd1);
    chk("store.rdata_raw", lsu_rdata, 32'h5555_0000);
    tick();

    // Memory never answers: 8 cycles in REQ/RESP, then error completion.
    lsu_reqValid = 1'b1; lsu_addr = 32'h0000_0300; lsu_wen = 1'b0; lsu_size = 2'b10;
    tick();
    lsu_reqValid = 1'b0;
    tick();                                   // REQ/RESP cycle 1
    chk("tmo.reqValid", 32'(mem_reqValid), 32'd1);
    for (int i = 0; i < 7; i++) tick();       // cycles 2..8
    chk("tmo.not_before_limit", 32'(lsu_respValid), 32'd0);
    chk("tmo.no_err_before", 32'(bus_err), 32'd0);
    tick();
    chk("tmo.resp", 32'(lsu_respValid), 32'd1);
    chk("tmo.err_data", lsu_rdata, 32'hDEAD_BEEF);
    chk("tmo.bus_err", 32'(bus_err), 32'd1);
    chk("tmo.req_dropped", 32'(mem_reqValid), 32'd0);
    mem_respValid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_respValid = 1'b0;
    chk("tmo.late_lsu", 32'(lsu_respValid), 32'd0);
    chk("tmo.late_ifu", 32'(ifu_respValid), 32'd0);
    chk("tmo.rdata_kept", lsu_rdata, 32'hDEAD_BEEF);
    chk("tmo.sticky", 32'(bus_err), 32'd1);
    tick();

    // Repeated fetch while the first is outstanding is dropped.
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_0400;
    tick();
    ifu_addr = 32'h0000_0500;
    tick();
    chk("dup.first_addr", mem_addr, 32'h0000_0400);
    tick();
    mem_respValid = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_respValid = 1'b0; ifu_reqValid = 1'b0;
    chk("dup.resp", 32'(ifu_respValid), 32'd1);
    chk("dup.rdata", ifu_rdata, 32'h0000_0077);
    tick();
    chk("dup.one_resp", 32'(ifu_respValid), 32'd0);
    chk("dup.no_second_req_a", 32'(mem_reqValid), 32'd0);
    tick();
    chk("dup.no_second_req_b", 32'(mem_reqValid), 32'd0);

    // Reset while in RESP.
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_0700;
    tick();
    ifu_reqValid = 1'b0;
    tick();
    chk("rst.in_req_addr", mem_addr, 32'h0000_0700);
    tick();                                   // RESP
    reset = 1'b0;
    #1;
    chk_all_zero("rst.mid");
    tick();
    reset = 1'b1;
    mem_respValid = 1'b1; mem_rdata = 32'h0000_0666;
    tick();
    mem_respValid = 1'b0;
    chk("rst.late_ignored", 32'(ifu_respValid), 32'd0);
    chk("rst.late_rdata", ifu_rdata, 32'd0);

    // Fresh fetch after reset; a new fetch lands in the same cycle as the pulse.
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_0800;
    tick();
    ifu_reqValid = 1'b0;
    tick();
    chk("post.addr", mem_addr, 32'h0000_0800);
    tick();
    mem_respValid = 1'b1; mem_rdata = 32'h0000_0099;
    tick();
    mem_respValid = 1'b0;
    chk("post.resp", 32'(ifu_respValid), 32'd1);
    chk("post.rdata", ifu_rdata, 32'h0000_0099);
    ifu_reqValid = 1'b1; ifu_addr = 32'h0000_0900;
    tick();
    ifu_reqValid = 1'b0;
    chk("same.idle_cycle", 32'(mem_reqValid), 32'd0);
    tick();
    chk("same.captured_valid", 32'(mem_reqValid), 32'd1);
    chk("same.captured_addr", mem_addr, 32'h0000_0900);
    tick();
    mem_respValid = 1'b1; mem_rdata = 32'h0000_0005;
    tick();
    mem_respValid = 1'b0;
    chk("same.resp", 32'(ifu_respValid), 32'd1);
    chk("same.rdata", ifu_rdata, 32'h0000_0005);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Arbitrates the CPU's instruction-fetch (ifu) and load/store (lsu) request ports onto one shared memory port with a valid/ready request handshake and a separate response strobe. It sits directly downstream of the cpu's io_ifu_* / io_lsu_* pins and upstream of the SoC memory or bus bridge. It holds one pending request per port, serializes them with LSU priority, registers responses, and bounds every transaction with a timeout.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles a transaction may stay in REQ+RESP before forced completion
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ifu_reqValid  in  1  fetch request event
- ifu_addr  in  AW  fetch address
- ifu_respValid  out  1  one-cycle fetch completion pulse
- ifu_rdata  out  DW  fetched word, valid with ifu_respValid
- lsu_reqValid  in  1  load/store request event
- lsu_addr  in  AW  byte address
- lsu_size  in  2  access size
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DW  store data (pre-lane-aligned)
- lsu_wmask  in  4  byte-lane enables
- lsu_respValid  out  1  one-cycle load/store completion pulse
- lsu_rdata  out  DW  raw load word, valid with lsu_respValid
- mem_reqValid  out  1  request valid to memory
- mem_reqReady  in  1  memory accepts request
- mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask  out  AW/2/1/DW/4  request payload, stable while mem_reqValid
- mem_respValid  in  1  memory completion strobe
- mem_rdata  in  DW  read data, valid with mem_respValid
- bus_err  out  1  sticky: set on any timeout

## Operation
- Each port has a one-entry pending slot (valid bit + payload). Any cycle with reqValid=1 and that port's slot empty and port not currently owner: payload captured, slot valid. reqValid while the port's slot is full or its transaction is in flight: ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE: if lsu slot valid -> owner=LSU, else if ifu slot valid -> owner=IFU; move owner's slot into the mem_* output registers, clear slot, go REQ. Neither -> stay.
- REQ: mem_reqValid=1. mem_reqReady=1 -> RESP.
- RESP: mem_respValid=1 -> register mem_rdata into owner's rdata, pulse owner's respValid next cycle, go IDLE.
- Writes also complete only on mem_respValid; lsu_rdata carries mem_rdata unchanged.
- Timeout: counter cleared on entering REQ, increments each cycle in REQ/RESP. On reaching TIMEOUT: owner's rdata=ERR_DATA, respValid pulse, bus_err<=1, mem_reqValid drops, go IDLE.
- mem_respValid outside RESP (late or spurious) is ignored.
- No address/size checking; alignment is the CPU's concern.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, both slots empty, all outputs 0 (respValids, rdatas, mem_reqValid, mem_* payload, bus_err).
- Request captured at edge N -> IDLE arbitrates at N+1 -> mem_reqValid high from N+2 (IDLE-only request: total 2 cycles reqValid-to-mem_reqValid).
- With mem_reqReady=1 and one-cycle memory: reqValid at N, respValid at N+5.
- Simultaneous ifu and lsu reqValid: both captured; LSU served first, IFU starts on the IDLE cycle after LSU's response.
- Request arriving for a port in the same cycle its respValid pulses: captured (port is no longer owner).
- mem_reqValid is never withdrawn before mem_reqReady except by timeout or reset.
- Reset mid-transaction: aborts with no response pulse; later mem_respValid ignored.
- respValid pulses are exactly one cycle; never both ports in the same cycle.

## Structure
- Package mem_arb_pkg: state enum (IDLE, REQ, RESP), owner enum (OWN_IFU, OWN_LSU), request payload struct (addr, size, wen, wdata, wmask).
- Submodule mem_arb_slot: one-entry pending buffer (capture, hold, pop); instantiated once per port, IFU tying write fields to 0.
- Timeout counter width $clog2(TIMEOUT+1).

## Test plan
- Single fetch, ifu_addr=0x8000_0000, mem_reqReady=1, mem returns 0x0000_0013 one cycle after accept -> ifu_respValid single pulse with ifu_rdata=0x13, five cycles after reqValid.
- Simultaneous ifu (0x100) and lsu load (0x200): mem_addr=0x200 first, then 0x100; lsu_respValid precedes ifu_respValid; never coincident.
- Store lsu_addr=0x10, wmask=4'b0100, wdata=0x00AB_0000, mem_reqReady held 0 for 3 cycles -> mem_reqValid and payload stable for those cycles; lsu_respValid follows mem_respValid.
- Memory never responds, TIMEOUT=8 -> lsu_respValid with lsu_rdata=0xDEAD_BEEF after 8 cycles in REQ/RESP; bus_err=1 and stays 1; late mem_respValid ignored.
- Second ifu_reqValid while first fetch outstanding -> ignored; exactly one mem request and one response.
- reset asserted in RESP -> all outputs 0 immediately; after release, subsequent mem_respValid ignored and a new fetch completes normally.
